// File: rtl/mux_arbiter.sv
// Round-robin owner of a shared 2:1 mux; caps each grant at MAX_BURST accepted beats.
// Latency: grant, sel and beat_cnt are registered, so a request is granted one cycle after it is seen.
// Backpressure: out_ready low freezes beat_cnt and holds the grant for as long as the owner keeps requesting.
module mux_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             out_ready,
    output logic             grant_a,
    output logic             grant_b,
    output logic             sel,
    output logic             out_valid,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t state;
    logic   prio;          // 0 favours A, 1 favours B when both request from IDLE
    logic   own_side;
    logic   own_req;
    logic   oth_req;
    logic   beat;
    logic   rel_now;
    logic   do_grant;
    logic   grant_side;    // 0 = A, 1 = B
    logic   go_idle;

    assign busy      = (state != IDLE);
    assign out_valid = (grant_a & req_a) | (grant_b & req_b);
    assign beat      = out_valid & out_ready;

    always_comb begin
        own_side   = (state == GNT_B);
        own_req    = own_side ? req_b : req_a;
        oth_req    = own_side ? req_a : req_b;
        rel_now    = busy & (~own_req | (beat & (beat_cnt == LAST_BEAT)));
        do_grant   = 1'b0;
        grant_side = 1'b0;
        go_idle    = 1'b0;
        if (!busy) begin
            do_grant   = req_a | req_b;
            grant_side = req_b & (~req_a | prio);
        end else if (rel_now) begin
            // Hand over to the waiting side first; re-grant only if nobody else wants it.
            if (oth_req) begin
                do_grant   = 1'b1;
                grant_side = ~own_side;
            end else if (own_req) begin
                do_grant   = 1'b1;
                grant_side = own_side;
            end else begin
                go_idle = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_a  <= 1'b0;
            grant_b  <= 1'b0;
            sel      <= 1'b0;
            beat_cnt <= '0;
            prio     <= 1'b0;
        end else if (do_grant) begin
            state    <= grant_side ? GNT_B : GNT_A;
            grant_a  <= ~grant_side;
            grant_b  <= grant_side;
            sel      <= grant_side;
            beat_cnt <= '0;
            prio     <= ~grant_side;
        end else if (go_idle) begin
            state    <= IDLE;
            grant_a  <= 1'b0;
            grant_b  <= 1'b0;
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: owner/burst/priority model checked every cycle plus directed literal checks.
module tb_mux_arbiter;

    localparam int MB    = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             req_a;
    logic             req_b;
    logic             out_ready;
    logic             grant_a;
    logic             grant_b;
    logic             sel;
    logic             out_valid;
    logic [CNT_W-1:0] beat_cnt;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    mux_arbiter #(.MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_ready (out_ready),
        .grant_a   (grant_a),
        .grant_b   (grant_b),
        .sel       (sel),
        .out_valid (out_valid),
        .beat_cnt  (beat_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the channel (0 none, 1 A, 2 B), beats taken in this grant,
    // which side wins a tie from idle, and the last routed side.
    int m_owner = 0;
    int m_cnt   = 0;
    int m_prio  = 1;
    int m_sel   = 0;

    task automatic give(input int who);
        m_owner = who;
        m_cnt   = 0;
        m_sel   = (who == 2) ? 1 : 0;
        m_prio  = 3 - who;
    endtask

    task automatic model_edge();
        bit ra;
        bit rb;
        bit mine;
        bit theirs;
        bit accepted;
        bit done;
        int other;
        ra = req_a;
        rb = req_b;
        if (m_owner == 0) begin
            if (ra && rb)  give(m_prio);
            else if (ra)   give(1);
            else if (rb)   give(2);
        end else begin
            other    = 3 - m_owner;
            mine     = (m_owner == 1) ? ra : rb;
            theirs   = (other == 1) ? ra : rb;
            accepted = mine && out_ready;
            done     = !mine || (accepted && (m_cnt + 1 == MB));
            if (!done) begin
                if (accepted) m_cnt = m_cnt + 1;
            end else if (theirs) begin
                give(other);
            end else if (mine) begin
                give(m_owner);
            end else begin
                m_owner = 0;
                m_cnt   = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0;
            m_cnt   = 0;
            m_prio  = 1;
            m_sel   = 0;
        end else begin
            model_edge();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_grant_a", grant_a, (m_owner == 1));
            chk("cmp_grant_b", grant_b, (m_owner == 2));
            chk("cmp_sel", sel, m_sel);
            chk("cmp_beat_cnt", beat_cnt, m_cnt);
            chk("cmp_busy", busy, (m_owner != 0));
            chk("cmp_out_valid", out_valid, (m_owner == 1 && req_a) || (m_owner == 2 && req_b));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_grant_a", grant_a, 0);
        chk("rst_grant_b", grant_b, 0);
        chk("rst_sel", sel, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);

        // A alone: grant after one edge, count 1..3, re-grant at the fourth beat.
        @(posedge clk); #2;
        rst = 1'b0; req_a = 1'b1; out_ready = 1'b1;
        step(1);
        chk("a_only_grant", grant_a, 1);
        chk("a_only_sel", sel, 0);
        chk("a_only_cnt0", beat_cnt, 0);
        step(3);
        chk("a_only_cnt3", beat_cnt, 3);
        step(1);
        chk("a_regrant_grant", grant_a, 1);
        chk("a_regrant_cnt", beat_cnt, 0);
        req_a = 1'b0;
        step(1);
        chk("a_drop_idle", busy, 0);

        // Both requesting from reset: A first, B after four beats with no idle gap.
        rst = 1'b1; #1;
        rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
        step(1);
        chk("both_first_a", grant_a, 1);
        step(4);
        chk("both_then_b", grant_b, 1);
        chk("both_then_b_sel", sel, 1);
        chk("both_then_b_cnt", beat_cnt, 0);
        step(4);
        chk("both_back_a", grant_a, 1);
        step(32);
        chk("alt_still_a", grant_a, 1);
        step(2);
        chk("alt_a_cnt2", beat_cnt, 2);

        // Owner drops mid-burst: B takes over on the next edge.
        req_a = 1'b0;
        step(1);
        chk("drop_grant_b", grant_b, 1);
        chk("drop_sel", sel, 1);
        chk("drop_cnt", beat_cnt, 0);

        // Stall: grant holds, counter frozen, out_valid stays high.
        req_a = 1'b1; out_ready = 1'b0;
        step(10);
        chk("stall_grant_b", grant_b, 1);
        chk("stall_cnt", beat_cnt, 0);
        chk("stall_valid", out_valid, 1);
        out_ready = 1'b1;
        step(1);
        chk("resume_cnt", beat_cnt, 1);
        step(2);
        chk("pre_rst_cnt", beat_cnt, 3);

        // Asynchronous reset mid-burst clears outputs before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("arst_grant_b", grant_b, 0);
        chk("arst_sel", sel, 0);
        chk("arst_cnt", beat_cnt, 0);
        chk("arst_busy", busy, 0);
        rst = 1'b0;
        step(1);
        chk("post_rst_a_first", grant_a, 1);
        chk("post_rst_sel", sel, 0);

        // Both drop while A owns: idle, sel held at 0.
        req_a = 1'b0; req_b = 1'b0;
        step(1);
        chk("idle_grant_a", grant_a, 0);
        chk("idle_busy", busy, 0);
        chk("idle_sel", sel, 0);
        chk("idle_valid", out_valid, 0);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
Round-robin arbiter that shares one 2:1 mux datapath (inputs A/B, select S, output Z) between two requesters. It owns the mux select and issues registered grants. It bounds each requester's occupancy to a burst of MAX_BURST accepted beats, so neither side can starve the other. It sits directly in front of the mux instance; sel drives the mux S port (sel=0 routes A to Z, sel=1 routes B).

Parameters:
MAX_BURST, 4, maximum accepted beats per grant before forced release; legal range 1..255
CNT_W, $clog2(MAX_BURST+1), width of burst counter (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req_a  input  1  requester A wants the channel; held high while it has data
req_b  input  1  requester B wants the channel; held high while it has data
out_ready  input  1  downstream consumer of mux output Z accepts a beat this cycle
grant_a  output  1  A owns the channel (registered)
grant_b  output  1  B owns the channel (registered)
sel  output  1  mux select: 0 = A, 1 = B (registered)
out_valid  output  1  granted requester is presenting a beat: (grant_a&req_a)|(grant_b&req_b)
beat_cnt  output  CNT_W  beats accepted in the current grant
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, GNT_A, GNT_B. grant_a=1 only in GNT_A, grant_b=1 only in GNT_B; never both.
- Reset (async, immediate, also mid-burst): state=IDLE, grant_a=grant_b=0, sel=0, beat_cnt=0, priority pointer prio=A. out_valid=0, busy=0.
- Beat: accepted when out_valid & out_ready on a clock edge. beat_cnt increments per beat and resets to 0 on every grant change or re-grant.
- IDLE: if neither req, stay. Otherwise grant next cycle: only one req -> grant it; both -> grant prio side. Latency from req rising to grant is 1 cycle.
- sel updates in the same edge as the grant and holds its last value in IDLE; it does not toggle without a grant change.
- Release of the current owner X (Y is the other requester) on the edge where either:
  - req_X=0 (dropped request, no beat), or
  - an accepted beat makes beat_cnt reach MAX_BURST.
- Next state on release:
  - req_Y=1: go directly to GNT_Y with no IDLE bubble.
  - else if req_X=1 (burst limit hit): re-grant X, beat_cnt=0.
  - else: IDLE.
- prio is set to the other side of whichever requester was last granted; it updates on every grant, including re-grants.
- out_ready low: no beat is counted, and the grant holds indefinitely while req stays high. Stalls never trigger release.
- Requests are level signals; no request queueing. A req pulse shorter than the grant latency is lost.
- Requests from the non-owner are ignored until the owner releases.
- MAX_BURST=1: the channel alternates each accepted beat when both sides request.

Test Plan:
- Reset then req_a=1 only, out_ready=1, MAX_BURST=4 -> grant_a=1 and sel=0 one cycle later; beat_cnt goes 1,2,3, then re-grant A at count 4 with beat_cnt=0; grant_b never asserts.
- req_a=req_b=1 from reset, out_ready=1 -> A granted first (prio=A); after 4 beats GNT_B with sel=1 and no IDLE cycle; after 4 more beats back to A. Alternation holds over 40 cycles.
- In GNT_A with beat_cnt=2, drop req_a with req_b=1 -> next edge grant_b=1, sel=1, beat_cnt=0.
- In GNT_B, hold out_ready=0 for 10 cycles with req_a=1 -> grant_b stays, beat_cnt frozen, out_valid=1. Raise out_ready -> counting resumes.
- Assert rst asynchronously mid-burst (GNT_B, beat_cnt=3) -> grant_b, sel, beat_cnt and busy clear before the next clock edge. After release with both requesting, A is granted first.
- Both requests drop in GNT_A -> IDLE next edge; sel stays 0, busy=0, out_valid=0.
